// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between a UART RX/TX pair and the register file.
// Parses write/read frames, issues register strobes, returns read data over TX.
module uart_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    RD_TIMEOUT = 16,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter logic [DATA_WIDTH-1:0] ERR_BYTE   = 8'hEE
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_VALID,
    input  logic                  PARITY_ERROR,
    input  logic                  FRAM_ERROR,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_BUSY,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VALID,
    output logic                  CMD_ERR,
    output logic                  CTRL_BUSY
);

    localparam int                CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_REQ  = 3'd5,
        TX_WAIT = 3'd6
    } state_t;

    state_t                state_q,      state_d;
    logic [DATA_WIDTH-1:0] tx_data_q,    tx_data_d;
    logic                  tx_valid_q,   tx_valid_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q,    rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
    logic                  rf_wr_en_q,   rf_wr_en_d;
    logic                  rf_rd_en_q,   rf_rd_en_d;
    logic                  cmd_err_q,    cmd_err_d;
    logic                  ctrl_busy_q,  ctrl_busy_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;

    logic good_byte_s;
    logic bad_byte_s;
    logic addr_ok_s;

    assign good_byte_s = RX_VALID & ~(PARITY_ERROR | FRAM_ERROR);
    assign bad_byte_s  = RX_VALID &  (PARITY_ERROR | FRAM_ERROR);
    assign addr_ok_s   = ((RX_DATA >> ADDR_WIDTH) == {DATA_WIDTH{1'b0}});

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            tx_data_q    <= {DATA_WIDTH{1'b0}};
            tx_valid_q   <= 1'b0;
            rf_addr_q    <= {ADDR_WIDTH{1'b0}};
            rf_wr_data_q <= {DATA_WIDTH{1'b0}};
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            ctrl_busy_q  <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            cmd_err_q    <= cmd_err_d;
            ctrl_busy_q  <= ctrl_busy_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and next-output logic; strobes default low so they last one cycle.
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        cmd_err_d    = 1'b0;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (good_byte_s) begin
                    if (RX_DATA == WR_CMD) begin
                        state_d = WR_ADDR;
                    end else if (RX_DATA == RD_CMD) begin
                        state_d = RD_ADDR;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end else if (bad_byte_s) begin
                    cmd_err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (good_byte_s && addr_ok_s) begin
                    rf_addr_d = RX_DATA[ADDR_WIDTH-1:0];
                    if (state_q == WR_ADDR) begin
                        state_d = WR_DATA;
                    end else begin
                        state_d    = RD_WAIT;
                        rf_rd_en_d = 1'b1;
                        cnt_d      = {CNT_W{1'b0}};
                    end
                end else if (RX_VALID) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            WR_DATA: begin
                if (good_byte_s) begin
                    rf_wr_data_d = RX_DATA;
                    rf_wr_en_d   = 1'b1;
                    state_d      = IDLE;
                end else if (bad_byte_s) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WR_DATA;
                end
            end
            RD_WAIT: begin
                // Valid data beats a timeout landing on the same edge.
                cnt_d = cnt_q + CNT_W'(1);
                if (RF_RD_VALID) begin
                    tx_data_d  = RF_RD_DATA;
                    tx_valid_d = 1'b1;
                    state_d    = TX_REQ;
                end else if (cnt_q == CNT_LAST) begin
                    tx_data_d  = ERR_BYTE;
                    tx_valid_d = 1'b1;
                    cmd_err_d  = 1'b1;
                    state_d    = TX_REQ;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            TX_REQ: begin
                if (TX_BUSY) begin
                    tx_valid_d = 1'b0;
                    state_d    = TX_WAIT;
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            TX_WAIT: begin
                if (!TX_BUSY) begin
                    state_d = IDLE;
                end else begin
                    state_d = TX_WAIT;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        ctrl_busy_d = (state_d != IDLE);
    end

    assign TX_DATA    = tx_data_q;
    assign TX_VALID   = tx_valid_q;
    assign RF_ADDR    = rf_addr_q;
    assign RF_WR_DATA = rf_wr_data_q;
    assign RF_WR_EN   = rf_wr_en_q;
    assign RF_RD_EN   = rf_rd_en_q;
    assign CMD_ERR    = cmd_err_q;
    assign CTRL_BUSY  = ctrl_busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames followed by random frames,
// with the bench acting as the register file and UART transmitter.
module tb_uart_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int T  = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] RX_DATA;
    logic          RX_VALID;
    logic          PARITY_ERROR;
    logic          FRAM_ERROR;
    logic [DW-1:0] TX_DATA;
    logic          TX_VALID;
    logic          TX_BUSY;
    logic [AW-1:0] RF_ADDR;
    logic [DW-1:0] RF_WR_DATA;
    logic          RF_WR_EN;
    logic          RF_RD_EN;
    logic [DW-1:0] RF_RD_DATA;
    logic          RF_RD_VALID;
    logic          CMD_ERR;
    logic          CTRL_BUSY;

    always #5 CLK = ~CLK;

    uart_cmd_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(T),
        .WR_CMD(8'hAA), .RD_CMD(8'hBB), .ERR_BYTE(8'hEE)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .PARITY_ERROR(PARITY_ERROR), .FRAM_ERROR(FRAM_ERROR),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_BUSY(TX_BUSY),
        .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA),
        .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_VALID(RF_RD_VALID),
        .CMD_ERR(CMD_ERR), .CTRL_BUSY(CTRL_BUSY)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_seen = 0, rd_seen = 0, wr_exp = 0, rd_exp = 0;
    logic [DW-1:0] mem [16];

    // Strobe counters catch any spurious register access across the whole run.
    always @(negedge CLK) begin
        if (RF_WR_EN === 1'b1) wr_seen++;
        if (RF_RD_EN === 1'b1) rd_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit pe, input bit fe);
        RX_DATA = b; RX_VALID = 1'b1; PARITY_ERROR = pe; FRAM_ERROR = fe;
        tick();
        RX_VALID = 1'b0; PARITY_ERROR = 1'b0; FRAM_ERROR = 1'b0;
    endtask

    task automatic expect_err(input string tag);
        chk({tag, "_err"}, {31'd0, CMD_ERR}, 32'd1);
        chk({tag, "_idle"}, {31'd0, CTRL_BUSY}, 32'd0);
        chk({tag, "_nostrobe"}, {30'd0, RF_WR_EN, RF_RD_EN}, 32'd0);
        tick();
        chk({tag, "_pulse"}, {31'd0, CMD_ERR}, 32'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] dv);
        send(8'hAA, 1'b0, 1'b0);
        chk("wr_op_err", {31'd0, CMD_ERR}, 32'd0);
        send({4'h0, a}, 1'b0, 1'b0);
        chk("wr_addr_busy", {30'd0, CTRL_BUSY, CMD_ERR}, 32'd2);
        send(dv, 1'b0, 1'b0);
        chk("wr_en", {31'd0, RF_WR_EN}, 32'd1);
        chk("wr_addr", {28'd0, RF_ADDR}, {28'd0, a});
        chk("wr_data", {24'd0, RF_WR_DATA}, {24'd0, dv});
        chk("wr_no_err_tx", {30'd0, CMD_ERR, TX_VALID}, 32'd0);
        wr_exp++;
        mem[a] = dv;
        tick();
        chk("wr_en_pulse", {30'd0, RF_WR_EN, CTRL_BUSY}, 32'd0);
    endtask

    // d = cycles after the RF_RD_EN cycle at which the register file answers.
    task automatic do_read(input logic [3:0] a, input int d, input bit noise, input int nb);
        logic [7:0] exp_b;
        bit to, bad;
        int resp;
        to    = (d >= T);
        exp_b = to ? 8'hEE : mem[a];
        resp  = to ? T : d + 1;
        bad   = 1'b0;
        send(8'hBB, 1'b0, 1'b0);
        chk("rd_op", {30'd0, CTRL_BUSY, CMD_ERR}, 32'd2);
        send({4'h0, a}, 1'b0, 1'b0);
        chk("rd_en", {31'd0, RF_RD_EN}, 32'd1);
        chk("rd_addr", {28'd0, RF_ADDR}, {28'd0, a});
        rd_exp++;
        for (int k = 0; k < resp; k++) begin
            RF_RD_VALID = (k == d);
            RF_RD_DATA  = (k == d) ? mem[a] : 8'($urandom);
            RX_DATA     = 8'h55;
            RX_VALID    = noise && (k == 0);
            tick();
            RX_VALID = 1'b0; RF_RD_VALID = 1'b0;
            if (k + 1 < resp && (CMD_ERR !== 1'b0 || TX_VALID !== 1'b0 || RF_RD_EN !== 1'b0))
                bad = 1'b1;
        end
        chk("rd_quiet", {31'd0, bad}, 32'd0);
        chk("tx_valid", {31'd0, TX_VALID}, 32'd1);
        chk("tx_data", {24'd0, TX_DATA}, {24'd0, exp_b});
        chk("rd_timeout_err", {31'd0, CMD_ERR}, {31'd0, to});
        // A stray read-valid outside the wait state must not disturb TX_DATA.
        RF_RD_VALID = 1'b1;
        RF_RD_DATA  = ~exp_b;
        bad = 1'b0;
        for (int i = 0; i <= nb; i++) begin
            tick();
            RF_RD_VALID = 1'b0;
            if (TX_VALID !== 1'b1 || TX_DATA !== exp_b || CMD_ERR !== 1'b0) bad = 1'b1;
        end
        chk("tx_hold", {31'd0, bad}, 32'd0);
        TX_BUSY = 1'b1;
        tick();
        chk("tx_drop", {30'd0, TX_VALID, CTRL_BUSY}, 32'd1);
        send(8'h55, 1'b0, 1'b0);
        chk("txw_ignore", {30'd0, CMD_ERR, CTRL_BUSY}, 32'd1);
        tick();
        TX_BUSY = 1'b0;
        tick();
        chk("rd_done", {30'd0, CTRL_BUSY, TX_VALID}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int kind, sub;
        RST = 1'b1; RX_DATA = 8'h00; RX_VALID = 1'b0; PARITY_ERROR = 1'b0;
        FRAM_ERROR = 1'b0; TX_BUSY = 1'b0; RF_RD_DATA = 8'h00; RF_RD_VALID = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        tick(); tick();
        chk("reset_outs", {7'd0, TX_DATA, TX_VALID, RF_ADDR, RF_WR_DATA,
                           RF_WR_EN, RF_RD_EN, CMD_ERR, CTRL_BUSY}, 32'd0);
        RST = 1'b0;
        tick();

        do_write(4'h3, 8'h5C);
        mem[7] = 8'h3A;
        do_read(4'h7, 2, 1'b0, 1);
        do_read(4'h2, 100, 1'b0, 0);
        mem[5] = 8'hC7;
        do_read(4'h5, T - 1, 1'b1, 2);

        send(8'hAA, 1'b0, 1'b0);
        send(8'h04, 1'b1, 1'b0);
        expect_err("par_addr");
        send(8'hBB, 1'b0, 1'b0);
        send(8'h1F, 1'b0, 1'b0);
        expect_err("addr_range");
        send(8'h55, 1'b0, 1'b0);
        expect_err("bad_op");
        send(8'h66, 1'b0, 1'b0);
        expect_err("bad_op2");
        send(8'hAA, 1'b0, 1'b1);
        expect_err("fram_op");

        send(8'hAA, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        RST = 1'b1;
        tick();
        chk("midrst_outs", {7'd0, TX_DATA, TX_VALID, RF_ADDR, RF_WR_DATA,
                            RF_WR_EN, RF_RD_EN, CMD_ERR, CTRL_BUSY}, 32'd0);
        RST = 1'b0;
        send(8'h5C, 1'b0, 1'b0);
        expect_err("midrst_data");

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: do_write(4'($urandom), 8'($urandom));
                1: do_read(4'($urandom), int'($urandom_range(1, T + 2)),
                           1'($urandom), int'($urandom_range(0, 3)));
                2: begin
                    do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB);
                    send(b, 1'($urandom), 1'b0);
                    expect_err("rnd_junk");
                end
                default: begin
                    sub = int'($urandom_range(0, 2));
                    send((sub == 1) ? 8'hBB : 8'hAA, 1'b0, 1'b0);
                    chk("rnd_mal_op", {31'd0, CMD_ERR}, 32'd0);
                    if (sub == 0) begin
                        send(8'($urandom_range(16, 255)), 1'b0, 1'b0);
                    end else if (sub == 1) begin
                        send(8'($urandom_range(0, 15)), 1'b0, 1'b1);
                    end else begin
                        send(8'($urandom_range(0, 15)), 1'b0, 1'b0);
                        send(8'($urandom), 1'b1, 1'b0);
                    end
                    expect_err("rnd_mal");
                end
            endcase
        end

        tick();
        chk("wr_count", wr_seen, wr_exp);
        chk("rd_count", rd_seen, rd_exp);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
